// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between instruction fetch and load/store,
// with tohost store interception and a sticky halt once the test signals completion.
module mem_port_arbiter #(
    parameter int unsigned               ADDR_WIDTH    = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter int unsigned               MEM_ADDR_BITS = 14,
    parameter logic [ADDR_WIDTH-1:0]     TOHOST_ADDR   = 32'h0000_1000
) (
    input  logic                     CLK,
    input  logic                     RST,

    input  logic                     imem_req_valid,
    output logic                     imem_req_ready,
    input  logic [ADDR_WIDTH-1:0]    imem_req_addr,
    output logic                     imem_resp_valid,
    output logic [DATA_WIDTH-1:0]    imem_resp_data,

    input  logic                     dmem_req_valid,
    output logic                     dmem_req_ready,
    input  logic [ADDR_WIDTH-1:0]    dmem_req_addr,
    input  logic                     dmem_req_wen,
    input  logic [3:0]               dmem_req_wstrb,
    input  logic [DATA_WIDTH-1:0]    dmem_req_wdata,
    output logic                     dmem_resp_valid,
    output logic [DATA_WIDTH-1:0]    dmem_resp_data,

    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,

    output logic [31:0]              tohost,
    output logic                     halted
);

    typedef enum logic {
        PRIO_IMEM = 1'b0,
        PRIO_DMEM = 1'b1
    } prio_e;

    prio_e       rr_q, rr_d;
    logic [31:0] tohost_q, tohost_d;
    logic        halted_q, halted_d;
    logic        resp_imem_q, resp_imem_d;
    logic        resp_dmem_q, resp_dmem_d;
    logic        resp_read_q, resp_read_d;

    logic        gnt_imem;
    logic        gnt_dmem;
    logic        tohost_store;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_imem = 1'b0;
        gnt_dmem = 1'b0;
        if (!RST && !halted_q) begin
            if (imem_req_valid && (!dmem_req_valid || rr_q == PRIO_IMEM)) begin
                gnt_imem = 1'b1;
            end else if (dmem_req_valid) begin
                gnt_dmem = 1'b1;
            end
        end
    end

    assign tohost_store = gnt_dmem && dmem_req_wen && (dmem_req_addr == TOHOST_ADDR);

    assign imem_req_ready = gnt_imem;
    assign dmem_req_ready = gnt_dmem;

    // The tohost store is absorbed here and never reaches the BRAM.
    assign mem_en    = (gnt_imem || gnt_dmem) && !tohost_store;
    assign mem_we    = (gnt_dmem && dmem_req_wen && !tohost_store) ? dmem_req_wstrb : 4'b0000;
    assign mem_addr  = gnt_dmem ? dmem_req_addr[MEM_ADDR_BITS+1:2]
                                : imem_req_addr[MEM_ADDR_BITS+1:2];
    assign mem_wdata = dmem_req_wdata;

    always_comb begin
        rr_d        = rr_q;
        tohost_d    = tohost_q;
        halted_d    = halted_q;
        resp_imem_d = gnt_imem;
        resp_dmem_d = gnt_dmem;
        resp_read_d = gnt_imem || (gnt_dmem && !dmem_req_wen);

        if (gnt_imem) begin
            rr_d = PRIO_DMEM;
        end else if (gnt_dmem) begin
            rr_d = PRIO_IMEM;
        end

        if (tohost_store) begin
            tohost_d = dmem_req_wdata[31:0];
            halted_d = halted_q | dmem_req_wdata[0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_q        <= PRIO_IMEM;
            tohost_q    <= '0;
            halted_q    <= 1'b0;
            resp_imem_q <= 1'b0;
            resp_dmem_q <= 1'b0;
            resp_read_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            tohost_q    <= tohost_d;
            halted_q    <= halted_d;
            resp_imem_q <= resp_imem_d;
            resp_dmem_q <= resp_dmem_d;
            resp_read_q <= resp_read_d;
        end
    end

    // Store acks return zero data; only BRAM reads forward mem_rdata.
    assign imem_resp_valid = resp_imem_q;
    assign dmem_resp_valid = resp_dmem_q;
    assign imem_resp_data  = (resp_imem_q && resp_read_q) ? mem_rdata : '0;
    assign dmem_resp_data  = (resp_dmem_q && resp_read_q) ? mem_rdata : '0;

    assign tohost = tohost_q;
    assign halted = halted_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS+2], imem_req_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a BRAM stand-in plus a transaction-level model
// (last-granted port, shadow memory, expected next responses) checked every cycle.
module tb_mem_port_arbiter;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam int          WORDS  = 16384;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req_valid = 1'b0;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr = '0;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dmem_req_valid = 1'b0;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr = '0;
    logic        dmem_req_wen = 1'b0;
    logic [3:0]  dmem_req_wstrb = '0;
    logic [31:0] dmem_req_wdata = '0;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] tohost;
    logic        halted;

    mem_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
        .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .tohost(tohost), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // BRAM stand-in: read-before-write, one cycle read latency.
    logic [31:0] bram [0:WORDS-1];
    always @(posedge CLK) begin
        if (mem_en) begin
            logic [31:0] w;
            w = bram[mem_addr];
            mem_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            bram[mem_addr] <= w;
        end
    end

    // Reference model state.
    logic [31:0] shadow [0:WORDS-1];
    bit          m_last_imem;
    bit          m_halted;
    logic [31:0] m_tohost;
    bit          m_ri, m_rd;
    logic [31:0] m_ri_data, m_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_last_imem = 1'b0;
        m_halted    = 1'b0;
        m_tohost    = '0;
        m_ri        = 1'b0;
        m_rd        = 1'b0;
        m_ri_data   = '0;
        m_rd_data   = '0;
    endtask

    // Holds RST for n cycles with both requesters pushing; nothing may move.
    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            RST = 1'b1;
            imem_req_valid = 1'b1;
            imem_req_addr  = $urandom_range(0, 255) << 2;
            dmem_req_valid = 1'b1;
            dmem_req_addr  = $urandom_range(0, 255) << 2;
            dmem_req_wen   = 1'($urandom_range(0, 1));
            dmem_req_wstrb = 4'hF;
            #1;
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_imem_ready", imem_req_ready, 0);
            check("rst_dmem_ready", dmem_req_ready, 0);
            check("rst_imem_resp_valid", imem_resp_valid, 0);
            check("rst_dmem_resp_valid", dmem_resp_valid, 0);
            check("rst_tohost", tohost, 0);
            check("rst_halted", halted, 0);
            model_reset();
        end
    endtask

    // One cycle: drive requests, compare everything against the model, advance the model.
    task automatic step(input bit iv, input logic [31:0] ia, input bit dv, input logic [31:0] da,
                        input bit dw, input logic [3:0] ds, input logic [31:0] dd);
        bit          g_i, g_d, th, en;
        logic [3:0]  we;
        logic [13:0] iw, dwi;
        @(negedge CLK);
        RST            = 1'b0;
        imem_req_valid = iv;
        imem_req_addr  = ia;
        dmem_req_valid = dv;
        dmem_req_addr  = da;
        dmem_req_wen   = dw;
        dmem_req_wstrb = ds;
        dmem_req_wdata = dd;
        #1;
        iw  = ia[15:2];
        dwi = da[15:2];
        g_i = !m_halted && iv && (!dv || !m_last_imem);
        g_d = !m_halted && dv && !g_i;
        th  = g_d && dw && (da == TOHOST);
        en  = (g_i || g_d) && !th;
        we  = (g_d && dw && !th) ? ds : 4'b0000;

        check("imem_req_ready", imem_req_ready, g_i);
        check("dmem_req_ready", dmem_req_ready, g_d);
        check("mem_en", mem_en, en);
        check("mem_we", mem_we, we);
        if (en) check("mem_addr", mem_addr, g_i ? iw : dwi);
        if (we != 0) check("mem_wdata", mem_wdata, dd);
        check("imem_resp_valid", imem_resp_valid, m_ri);
        check("dmem_resp_valid", dmem_resp_valid, m_rd);
        if (m_ri) check("imem_resp_data", imem_resp_data, m_ri_data);
        if (m_rd) check("dmem_resp_data", dmem_resp_data, m_rd_data);
        check("tohost", tohost, m_tohost);
        check("halted", halted, m_halted);

        m_ri      = g_i;
        m_ri_data = shadow[iw];
        m_rd      = g_d;
        m_rd_data = dw ? 32'h0 : shadow[dwi];
        if (g_i) m_last_imem = 1'b1;
        if (g_d) m_last_imem = 1'b0;
        if (g_d && dw && !th)
            for (int b = 0; b < 4; b++)
                if (ds[b]) shadow[dwi][8*b +: 8] = dd[8*b +: 8];
        if (th) begin
            m_tohost = dd;
            if (dd[0]) m_halted = 1'b1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle(input bit allow_tohost);
        logic [31:0] ia, da, dd;
        bit dw;
        ia = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        da = ($urandom_range(0, 65) << 2) | $urandom_range(0, 3);
        if (allow_tohost && $urandom_range(0, 9) == 0) da = TOHOST;
        dw = 1'($urandom_range(0, 1));
        dd = $urandom;
        if (da == TOHOST) dd[0] = 1'b0;
        step(($urandom_range(0, 3) != 0), ia, ($urandom_range(0, 3) != 0), da, dw,
             4'($urandom_range(0, 15)), dd);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            bram[i]   = i * 32'h9E37_79B9;
            shadow[i] = i * 32'h9E37_79B9;
        end
        bram[16'h10]   = 32'hDEADBEEF;
        shadow[16'h10] = 32'hDEADBEEF;
        bram[16'h41]   = 32'h1122_3344;
        shadow[16'h41] = 32'h1122_3344;
        model_reset();

        do_reset(3);

        // First post-reset cycle with both valid goes to imem; fetch from 0x40.
        step(1, 32'h40, 1, 32'h200, 0, 0, 0);
        check("first_grant_imem", imem_req_ready, 1);
        check("fetch_mem_addr", mem_addr, 14'h10);
        idle();
        check("fetch_resp_valid", imem_resp_valid, 1);
        check("fetch_resp_data", imem_resp_data, 32'hDEADBEEF);
        check("fetch_no_dmem_resp", dmem_resp_valid, 0);

        // Contention after a dmem access: I,D,I,D,I,D.
        step(0, 0, 1, 32'h80, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 32'h100 + 32'(i * 4), 1, 32'h20 + 32'(i * 4), 0, 0, 0);
            check("contention_imem_ready", imem_req_ready, (i % 2 == 0) ? 1 : 0);
        end
        idle();

        // Byte-lane store then read back.
        step(0, 0, 1, 32'h104, 1, 4'b0010, 32'h0000_AB00);
        check("bytestore_we", mem_we, 4'b0010);
        check("bytestore_addr", mem_addr, 14'h41);
        idle();
        step(0, 0, 1, 32'h104, 0, 0, 0);
        idle();
        check("bytestore_readback", dmem_resp_data, 32'h1122_AB44);

        for (int c = 0; c < 400; c++) rand_cycle(1);

        // tohost: non-halting value, then the halting one.
        step(0, 0, 1, TOHOST, 1, 4'hF, 32'h0000_0002);
        check("tohost_mem_en", mem_en, 0);
        idle();
        check("tohost_value2", tohost, 32'h2);
        check("tohost_not_halted", halted, 0);
        step(0, 0, 1, TOHOST, 1, 4'h1, 32'h0000_0001);
        step(1, 32'h40, 1, 32'h40, 0, 0, 0);
        check("tohost_value1", tohost, 32'h1);
        check("halted_set", halted, 1);
        check("halt_store_ack", dmem_resp_valid, 1);
        check("halt_imem_ready", imem_req_ready, 0);
        for (int c = 0; c < 20; c++) rand_cycle(0);
        check("halt_still_frozen", dmem_req_ready | imem_req_ready, 0);

        // Reset mid-response: the load's response must be dropped.
        do_reset(1);
        step(0, 0, 1, 32'h40, 0, 0, 0);
        check("midrst_load_accept", dmem_req_ready, 1);
        do_reset(1);
        step(1, 32'h44, 1, 32'h48, 0, 0, 0);
        check("post_midrst_imem_first", imem_req_ready, 1);
        check("post_midrst_no_resp", dmem_resp_valid, 0);
        for (int c = 0; c < 200; c++) rand_cycle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
